// File: rtl/mmu_req_arbiter.sv
// Shares one translation path (direct/DMW decode + TLB search port)
// between the fetch and data requesters, with a valid/ready response.
module mmu_req_arbiter #(
  parameter int PALEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      csr_crmd,
  input  logic [31:0]      csr_dmw0,
  input  logic [31:0]      csr_dmw1,
  input  logic [9:0]       csr_asid,
  input  logic             flush,
  input  logic             inst_req,
  input  logic [PALEN-1:0] inst_vaddr,
  output logic             inst_addr_ok,
  output logic             inst_rsp_valid,
  input  logic             inst_rsp_ready,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [PALEN-1:0] data_vaddr,
  output logic             data_addr_ok,
  output logic             data_rsp_valid,
  input  logic             data_rsp_ready,
  output logic [PALEN-1:0] rsp_paddr,
  output logic [1:0]       rsp_mat,
  output logic [2:0]       rsp_fault,
  output logic [18:0]      s_vppn,
  output logic             s_va_bit12,
  output logic [9:0]       s_asid,
  input  logic             s_found,
  input  logic [19:0]      s_ppn,
  input  logic [5:0]       s_ps,
  input  logic [1:0]       s_plv,
  input  logic [1:0]       s_mat,
  input  logic             s_d,
  input  logic             s_v
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_t;

  state_t state_q, state_d;

  // last_q / owner_q: 0 = fetch, 1 = data
  logic        last_q;
  logic        owner_q;
  logic        wr_q;
  logic [31:0] va_q;
  logic [31:0] pa_q;
  logic [1:0]  mat_q;
  logic [2:0]  flt_q;

  logic        can_grant;
  logic        grant_i;
  logic        grant_d;
  logic [31:0] sel_va;
  logic        sel_wr;
  logic [1:0]  plv;
  logic        mapped;
  logic        dmw0_hit;
  logic        dmw1_hit;
  logic        cls_hit;
  logic [31:0] cls_pa;
  logic [1:0]  cls_mat;
  logic        in_lookup;
  logic [31:0] tlb_pa;
  logic [2:0]  tlb_flt;
  logic        rsp_fire;
  logic        ld_acc;
  logic        ld_cls;
  logic        ld_tlb;

  assign plv    = csr_crmd[1:0];
  assign mapped = csr_crmd[4] & ~csr_crmd[3];

  // Round-robin grant; on a tie the side that did not win last goes.
  always_comb begin
    can_grant = (state_q == IDLE) & ~flush & ~reset;
    grant_i   = can_grant & inst_req & (~data_req | last_q);
    grant_d   = can_grant & data_req & (~inst_req | ~last_q);
    sel_va    = grant_d ? data_vaddr : inst_vaddr;
    sel_wr    = grant_d & data_wr;
  end

  assign inst_addr_ok = grant_i;
  assign data_addr_ok = grant_d;

  // Direct / DMW classification of the address being accepted.
  always_comb begin
    dmw0_hit = ((plv == 2'd0 & csr_dmw0[0]) |
                (plv == 2'd3 & csr_dmw0[3])) &
               (sel_va[31:29] == csr_dmw0[31:29]);
    dmw1_hit = ((plv == 2'd0 & csr_dmw1[0]) |
                (plv == 2'd3 & csr_dmw1[3])) &
               (sel_va[31:29] == csr_dmw1[31:29]);
    cls_hit  = ~mapped | dmw0_hit | dmw1_hit;
    cls_pa   = sel_va;
    cls_mat  = 2'd0;
    if (~mapped) begin
      cls_pa  = sel_va;
      cls_mat = 2'd0;
    end else if (dmw0_hit) begin
      cls_pa  = {csr_dmw0[27:25], sel_va[28:0]};
      cls_mat = csr_dmw0[5:4];
    end else if (dmw1_hit) begin
      cls_pa  = {csr_dmw1[27:25], sel_va[28:0]};
      cls_mat = csr_dmw1[5:4];
    end
  end

  assign in_lookup  = (state_q == LOOKUP);
  assign s_vppn     = in_lookup ? va_q[31:13] : 19'd0;
  assign s_va_bit12 = in_lookup & va_q[12];
  assign s_asid     = in_lookup ? csr_asid : 10'd0;

  // TLB result: address and prioritised fault code.
  always_comb begin
    tlb_pa = (s_ps == 6'd12) ? {s_ppn, va_q[11:0]}
                             : {s_ppn[19:9], va_q[20:0]};
    if (~s_found)
      tlb_flt = 3'd1;
    else if (~s_v)
      tlb_flt = 3'd2;
    else if (plv > s_plv)
      tlb_flt = 3'd3;
    else if (wr_q & ~s_d)
      tlb_flt = 3'd4;
    else
      tlb_flt = 3'd0;
  end

  assign inst_rsp_valid = (state_q == RESP) & ~owner_q;
  assign data_rsp_valid = (state_q == RESP) & owner_q;
  assign rsp_fire = owner_q ? data_rsp_ready : inst_rsp_ready;
  assign rsp_paddr = pa_q;
  assign rsp_mat   = mat_q;
  assign rsp_fault = flt_q;

  // Next-state and load enables.
  always_comb begin
    state_d = state_q;
    ld_acc  = 1'b0;
    ld_cls  = 1'b0;
    ld_tlb  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_i | grant_d) begin
          ld_acc  = 1'b1;
          ld_cls  = cls_hit;
          state_d = cls_hit ? RESP : LOOKUP;
        end
      end
      LOOKUP: begin
        ld_tlb  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_fire)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      ld_tlb  = 1'b0;
    end
  end

  // State, accepted request and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      va_q    <= 32'd0;
      pa_q    <= 32'd0;
      mat_q   <= 2'd0;
      flt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      if (ld_acc) begin
        va_q    <= sel_va;
        wr_q    <= sel_wr;
        owner_q <= grant_d;
        last_q  <= grant_d;
      end
      if (ld_cls) begin
        pa_q  <= cls_pa;
        mat_q <= cls_mat;
        flt_q <= 3'd0;
      end
      if (ld_tlb) begin
        pa_q  <= tlb_pa;
        mat_q <= s_mat;
        flt_q <= tlb_flt;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{csr_crmd[31:5], csr_crmd[2],
                         csr_dmw0[28], csr_dmw0[24:6], csr_dmw0[2:1],
                         csr_dmw1[28], csr_dmw1[24:6], csr_dmw1[2:1]};

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Bench for mmu_req_arbiter: directed scenarios plus randomized
// transactions checked against a rule-level translation model.
module tb_mmu_req_arbiter;

  logic        clk = 0;
  logic        reset;
  logic [31:0] csr_crmd, csr_dmw0, csr_dmw1;
  logic [9:0]  csr_asid;
  logic        flush;
  logic        inst_req, inst_addr_ok, inst_rsp_valid, inst_rsp_ready;
  logic [31:0] inst_vaddr;
  logic        data_req, data_wr, data_addr_ok;
  logic        data_rsp_valid, data_rsp_ready;
  logic [31:0] data_vaddr;
  logic [31:0] rsp_paddr;
  logic [1:0]  rsp_mat;
  logic [2:0]  rsp_fault;
  logic [18:0] s_vppn;
  logic        s_va_bit12;
  logic [9:0]  s_asid;
  logic        s_found, s_d, s_v;
  logic [19:0] s_ppn;
  logic [5:0]  s_ps;
  logic [1:0]  s_plv, s_mat;

  int errors = 0;
  int checks = 0;

  mmu_req_arbiter #(.PALEN(32)) dut (
    .clk(clk), .reset(reset),
    .csr_crmd(csr_crmd), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
    .csr_asid(csr_asid), .flush(flush),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr),
    .inst_addr_ok(inst_addr_ok), .inst_rsp_valid(inst_rsp_valid),
    .inst_rsp_ready(inst_rsp_ready),
    .data_req(data_req), .data_wr(data_wr), .data_vaddr(data_vaddr),
    .data_addr_ok(data_addr_ok), .data_rsp_valid(data_rsp_valid),
    .data_rsp_ready(data_rsp_ready),
    .rsp_paddr(rsp_paddr), .rsp_mat(rsp_mat), .rsp_fault(rsp_fault),
    .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_found(s_found), .s_ppn(s_ppn), .s_ps(s_ps), .s_plv(s_plv),
    .s_mat(s_mat), .s_d(s_d), .s_v(s_v)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected translation computed straight from the address-map rules.
  function automatic void ref_xlate(
    input bit is_d, input logic [31:0] va, input bit wr_in,
    output logic [31:0] pa, output logic [1:0] mat,
    output logic [2:0] flt, output int lat);
    longint unsigned p;
    logic [31:0] d;
    int plv;
    bit wr;
    wr  = is_d && wr_in;
    plv = int'(csr_crmd & 32'd3);
    if (!(csr_crmd[4] == 1'b1 && csr_crmd[3] == 1'b0)) begin
      pa = va; mat = 0; flt = 0; lat = 1;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? csr_dmw0 : csr_dmw1;
      if (((plv == 0 && d[0]) || (plv == 3 && d[3])) &&
          (va >> 29) == (d >> 29)) begin
        pa  = (((d >> 25) & 32'd7) << 29) | (va & 32'h1FFF_FFFF);
        mat = 2'((d >> 4) & 32'd3);
        flt = 0; lat = 1;
        return;
      end
    end
    lat = 2;
    mat = s_mat;
    if (s_ps == 6'd12)
      p = longint'(s_ppn) * 4096 + longint'(va) % 4096;
    else
      p = (longint'(s_ppn) / 512) * 64'd2097152 +
          longint'(va) % 2097152;
    pa = p[31:0];
    if (!s_found) flt = 1;
    else if (!s_v) flt = 2;
    else if (plv > int'(s_plv)) flt = 3;
    else if (wr && !s_d) flt = 4;
    else flt = 0;
  endfunction

  // Drives one request and collects what the DUT answers.
  task automatic do_xact(
    input bit is_d, input logic [31:0] va, input bit wr,
    output bit acc, output int lat, output logic [31:0] pa,
    output logic [1:0] mat, output logic [2:0] flt,
    output bit wrong, output logic [18:0] vppn_seen);
    bit got;
    data_wr = wr;
    if (is_d) begin data_req = 1; data_vaddr = va; end
    else begin inst_req = 1; inst_vaddr = va; end
    #1;
    acc   = is_d ? data_addr_ok : inst_addr_ok;
    wrong = is_d ? inst_addr_ok : data_addr_ok;
    tick();
    inst_req = 0; data_req = 0;
    lat = 1; vppn_seen = 0;
    got = is_d ? data_rsp_valid : inst_rsp_valid;
    while (!got && lat < 6) begin
      if (s_vppn != 0) vppn_seen = s_vppn;
      if (is_d ? inst_rsp_valid : data_rsp_valid) wrong = 1;
      tick();
      lat++;
      got = is_d ? data_rsp_valid : inst_rsp_valid;
    end
    if (is_d ? inst_rsp_valid : data_rsp_valid) wrong = 1;
    pa = rsp_paddr; mat = rsp_mat; flt = rsp_fault;
    inst_rsp_ready = 1; data_rsp_ready = 1;
    tick();
    inst_rsp_ready = 0; data_rsp_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    csr_crmd = 32'h08;
    do_reset();
    inst_req = 1; inst_vaddr = 32'h1234_5678;
    tick();
    inst_req = 0;
    reset = 1;
    data_req = 1; inst_req = 1;
    #1;
    checks++;
    if (inst_addr_ok !== 0 || data_addr_ok !== 0) begin
      errors++;
      $display("FAIL reset_addr_ok: got %b%b want 00",
               inst_addr_ok, data_addr_ok);
    end
    tick();
    checks++;
    if ({inst_rsp_valid, data_rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_rsp_valid: got %b%b want 00",
               inst_rsp_valid, data_rsp_valid);
    end
    checks++;
    if ({rsp_paddr, rsp_mat, rsp_fault} !== 37'd0) begin
      errors++;
      $display("FAIL reset_rsp_regs: got pa %h mat %0d flt %0d want 0",
               rsp_paddr, rsp_mat, rsp_fault);
    end
    checks++;
    if ({s_vppn, s_va_bit12, s_asid} !== 30'd0) begin
      errors++;
      $display("FAIL reset_s_port: got %h want 0", s_vppn);
    end
    data_req = 0; inst_req = 0;
    reset = 0;
    tick();
  endtask

  task automatic test_direct();
    bit acc, wrong; int lat;
    logic [31:0] pa; logic [1:0] mat; logic [2:0] flt;
    logic [18:0] vs;
    csr_crmd = 32'h08;
    do_xact(0, 32'h1C00_0100, 1, acc, lat, pa, mat, flt, wrong, vs);
    checks++;
    if (!acc || lat != 1 || wrong) begin
      errors++;
      $display("FAIL direct_timing: acc %0d lat %0d wrong %0d want 1 1 0",
               acc, lat, wrong);
    end
    checks++;
    if (pa !== 32'h1C00_0100 || flt !== 0 || mat !== 0 || vs !== 0) begin
      errors++;
      $display("FAIL direct_result: pa %h flt %0d vppn %h want 1c000100 0 0",
               pa, flt, vs);
    end
  endtask

  task automatic test_dmw();
    bit acc, wrong; int lat;
    logic [31:0] pa; logic [1:0] mat; logic [2:0] flt;
    logic [18:0] vs;
    csr_crmd = 32'h10; csr_dmw0 = 32'hA000_0011; csr_dmw1 = 0;
    do_xact(1, 32'hA000_1234, 0, acc, lat, pa, mat, flt, wrong, vs);
    checks++;
    if (!acc || lat != 1 || wrong) begin
      errors++;
      $display("FAIL dmw_timing: acc %0d lat %0d wrong %0d want 1 1 0",
               acc, lat, wrong);
    end
    checks++;
    if (pa !== 32'h0000_1234 || mat !== 1 || flt !== 0) begin
      errors++;
      $display("FAIL dmw_result: pa %h mat %0d flt %0d want 00001234 1 0",
               pa, mat, flt);
    end
  endtask

  task automatic test_tlb();
    bit acc, wrong; int lat, elat;
    logic [31:0] pa, epa; logic [1:0] mat, emat;
    logic [2:0] flt, eflt; logic [18:0] vs;
    csr_crmd = 32'h10; csr_dmw0 = 0; csr_dmw1 = 0;
    s_found = 1; s_ppn = 20'h12345; s_v = 1; s_d = 0;
    s_plv = 0; s_mat = 2;
    for (int i = 0; i < 2; i++) begin
      s_ps = (i == 0) ? 6'd12 : 6'd21;
      ref_xlate(1, 32'h0040_3ABC, 1, epa, emat, eflt, elat);
      do_xact(1, 32'h0040_3ABC, 1, acc, lat, pa, mat, flt, wrong, vs);
      checks++;
      if (!acc || lat != 2 || wrong || vs !== 19'h201) begin
        errors++;
        $display("FAIL tlb_timing%0d: acc %0d lat %0d vppn %h want 1 2 201",
                 i, acc, lat, vs);
      end
      checks++;
      if (pa !== epa || mat !== emat || flt !== 4) begin
        errors++;
        $display("FAIL tlb_store%0d: pa %h mat %0d flt %0d want %h %0d 4",
                 i, pa, mat, flt, epa, emat);
      end
    end
  endtask

  task automatic test_faults();
    bit acc, wrong; int lat;
    logic [31:0] pa; logic [1:0] mat; logic [2:0] flt;
    logic [18:0] vs;
    logic [2:0] want [3] = '{3'd1, 3'd3, 3'd2};
    csr_dmw0 = 0; csr_dmw1 = 0; s_ps = 12; s_d = 1; s_plv = 0;
    for (int i = 0; i < 3; i++) begin
      csr_crmd = (i == 0) ? 32'h10 : 32'h13;
      s_found  = (i != 0);
      s_v      = (i != 2);
      do_xact(0, 32'h0080_0000, 0, acc, lat, pa, mat, flt, wrong, vs);
      checks++;
      if (flt !== want[i] || lat != 2) begin
        errors++;
        $display("FAIL fault%0d: flt %0d lat %0d want %0d 2",
                 i, flt, lat, want[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    bit exp_d, last_d;
    logic [31:0] pa0;
    csr_crmd = 32'h08;
    do_reset();
    last_d = 0;
    inst_vaddr = 32'h0000_1111; data_vaddr = 32'h0000_2222;
    inst_req = 1; data_req = 1; data_wr = 0;
    for (int i = 0; i < 4; i++) begin
      exp_d = !last_d;
      last_d = exp_d;
      #1;
      checks++;
      if (data_addr_ok !== exp_d || inst_addr_ok !== !exp_d) begin
        errors++;
        $display("FAIL rr_grant%0d: got i%b d%b want d%b",
                 i, inst_addr_ok, data_addr_ok, exp_d);
      end
      tick();
      pa0 = exp_d ? 32'h0000_2222 : 32'h0000_1111;
      for (int h = 0; h < ((i == 0) ? 5 : 0); h++) begin
        checks++;
        if (data_rsp_valid !== exp_d || inst_rsp_valid !== !exp_d ||
            rsp_paddr !== pa0 || inst_addr_ok || data_addr_ok) begin
          errors++;
          $display("FAIL rr_hold%0d: v %b%b pa %h want d%b pa %h",
                   h, inst_rsp_valid, data_rsp_valid, rsp_paddr,
                   exp_d, pa0);
        end
        tick();
      end
      checks++;
      if (data_rsp_valid !== exp_d || inst_rsp_valid !== !exp_d ||
          rsp_paddr !== pa0) begin
        errors++;
        $display("FAIL rr_rsp%0d: v %b%b pa %h want d%b pa %h",
                 i, inst_rsp_valid, data_rsp_valid, rsp_paddr, exp_d, pa0);
      end
      inst_rsp_ready = 1; data_rsp_ready = 1;
      #1;
      checks++;
      if (inst_addr_ok || data_addr_ok) begin
        errors++;
        $display("FAIL rr_complete_grant%0d: got %b%b want 00",
                 i, inst_addr_ok, data_addr_ok);
      end
      tick();
      inst_rsp_ready = 0; data_rsp_ready = 0;
    end
    inst_req = 0; data_req = 0;
  endtask

  task automatic test_flush();
    logic [31:0] epa; logic [1:0] emat; logic [2:0] eflt; int elat;
    csr_crmd = 32'h10; csr_dmw0 = 0; csr_dmw1 = 0;
    s_found = 1; s_v = 1; s_d = 1; s_plv = 0; s_ps = 12;
    inst_req = 1; inst_vaddr = 32'h0040_3ABC;
    #1;
    checks++;
    if (inst_addr_ok !== 1) begin
      errors++;
      $display("FAIL flush_accept: got %b want 1", inst_addr_ok);
    end
    tick();
    inst_req = 0; flush = 1;
    #1;
    checks++;
    if (s_vppn !== 19'h201) begin
      errors++;
      $display("FAIL flush_lookup_vppn: got %h want 201", s_vppn);
    end
    tick();
    inst_req = 1; inst_vaddr = 32'h0000_5000;
    #1;
    checks++;
    if (inst_addr_ok !== 0 || inst_rsp_valid !== 0) begin
      errors++;
      $display("FAIL flush_hold: ok %b v %b want 0 0",
               inst_addr_ok, inst_rsp_valid);
    end
    tick();
    flush = 0;
    #1;
    checks++;
    if (inst_addr_ok !== 1 || inst_rsp_valid !== 0) begin
      errors++;
      $display("FAIL flush_regrant: ok %b v %b want 1 0",
               inst_addr_ok, inst_rsp_valid);
    end
    ref_xlate(0, 32'h0000_5000, 0, epa, emat, eflt, elat);
    tick();
    inst_req = 0;
    tick();
    checks++;
    if (inst_rsp_valid !== 1 || rsp_paddr !== epa || rsp_fault !== eflt) begin
      errors++;
      $display("FAIL flush_next_rsp: v %b pa %h flt %0d want 1 %h %0d",
               inst_rsp_valid, rsp_paddr, rsp_fault, epa, eflt);
    end
    inst_rsp_ready = 1;
    tick();
    inst_rsp_ready = 0;
  endtask

  task automatic test_random();
    bit acc, wrong, is_d, wr; int lat, elat, m;
    logic [31:0] va, pa, epa; logic [1:0] mat, emat;
    logic [2:0] flt, eflt; logic [18:0] vs;
    logic [1:0] plv;
    for (int n = 0; n < 60; n++) begin
      m   = int'($urandom_range(0, 5));
      plv = 2'($urandom);
      if ($urandom_range(0, 2) != 0) plv = {plv[0], plv[0]};
      case (m)
        0: csr_crmd = 32'h08 | 32'(plv);
        1: csr_crmd = 32'h00 | 32'(plv);
        2: csr_crmd = 32'h18 | 32'(plv);
        default: csr_crmd = 32'h10 | 32'(plv);
      endcase
      csr_dmw0 = $urandom; csr_dmw1 = $urandom;
      csr_asid = 10'($urandom);
      s_found = ($urandom_range(0, 4) != 0);
      s_v = ($urandom_range(0, 4) != 0);
      s_d = 1'($urandom); s_plv = 2'($urandom); s_mat = 2'($urandom);
      s_ppn = 20'($urandom); s_ps = $urandom_range(0, 1) ? 6'd12 : 6'd21;
      va = $urandom; is_d = 1'($urandom); wr = 1'($urandom);
      ref_xlate(is_d, va, wr, epa, emat, eflt, elat);
      do_xact(is_d, va, wr, acc, lat, pa, mat, flt, wrong, vs);
      checks++;
      if (!acc || wrong || lat != elat || pa !== epa || mat !== emat ||
          flt !== eflt) begin
        errors++;
        $display("FAIL rand%0d: acc %0d wr %0d lat %0d pa %h mat %0d flt %0d want lat %0d pa %h mat %0d flt %0d",
                 n, acc, wrong, lat, pa, mat, flt, elat, epa, emat, eflt);
      end
    end
  endtask

  initial begin
    reset = 1; flush = 0;
    csr_crmd = 0; csr_dmw0 = 0; csr_dmw1 = 0; csr_asid = 10'h2A;
    inst_req = 0; inst_vaddr = 0; inst_rsp_ready = 0;
    data_req = 0; data_wr = 0; data_vaddr = 0; data_rsp_ready = 0;
    s_found = 0; s_ppn = 0; s_ps = 12; s_plv = 0; s_mat = 0;
    s_d = 0; s_v = 0;
    test_reset();
    test_direct();
    test_dmw();
    test_tlb();
    test_faults();
    test_round_robin();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
